ysyx_23060136_pipe_skid_seg: RTL and testbench

Parametrised pipeline segment register with a valid/ready handshake and a two-entry skid buffer. It is the successor to the fixed-payload stage registers between IFU/IDU/EXU/MEM/WBU. Any stage boundary can instantiate it with a packed payload. It replaces global stall/flush wiring with local back-pressure, a registered upstream ready, flush-to-bubble, and a saturating stall counter for performance tuning.

---
 rtl/ysyx_23060136_pipe_skid_seg_pkg.sv | 25 ++
 rtl/ysyx_23060136_pipe_skid_seg_if.sv | 29 ++
 rtl/ysyx_23060136_pipe_skid_seg_sat_cnt.sv | 19 +
 rtl/ysyx_23060136_pipe_skid_seg.sv | 100 ++++++++++
 tb/tb_ysyx_23060136_pipe_skid_seg.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060136_pipe_skid_seg_pkg.sv
// Shared types and default widths for the valid/ready pipeline segment registers.
// Stage payloads are packed structs cast to DATA_W at the instantiation site.
package ysyx_23060136_PIPE_PKG;

  localparam int PIPE_DATA_W = 256;
  localparam int PIPE_CNT_W  = 32;

  // The state value doubles as the occupancy count driven on occ_o.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_seg_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] alu_res;
    logic [4:0]  rd;
    logic        wen;
    logic        commit;
    logic        halt;
  } exu_mem_pld_t;

endpackage

// File: rtl/ysyx_23060136_pipe_skid_seg_if.sv
// Handshake bundle between a producer stage, the skid segment and its consumer.
interface ysyx_23060136_pipe_skid_seg_if
  import ysyx_23060136_PIPE_PKG::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
);

  logic              flush_i;
  logic              up_valid_i;
  logic              up_ready_o;
  logic [DATA_W-1:0] up_data_i;
  logic              dn_valid_o;
  logic              dn_ready_i;
  logic [DATA_W-1:0] dn_data_o;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output flush_i, up_valid_i, up_data_i, dn_ready_i,
    input  up_ready_o, dn_valid_o, dn_data_o, occ_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, up_valid_i, up_data_i, dn_ready_i,
    output up_ready_o, dn_valid_o, dn_data_o, occ_o, stall_cnt_o
  );

endinterface

// File: rtl/ysyx_23060136_pipe_skid_seg_sat_cnt.sv
// Saturating up-counter, shared by the performance counters.
module ysyx_23060136_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ysyx_23060136_pipe_skid_seg.sv
// Pipeline segment register with a two-entry skid buffer, registered upstream
// ready, flush-to-bubble and a saturating stall counter.
module ysyx_23060136_pipe_skid_seg
  import ysyx_23060136_PIPE_PKG::*;
#(
  parameter int                DATA_W = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = PIPE_CNT_W
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_23060136_pipe_skid_seg_if.slave bus
);

  pipe_seg_state_t   state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_ready_q;
  logic              dn_valid;
  logic              up_fire;
  logic              dn_fire;

  assign dn_valid = (state_q != EMPTY);
  assign up_fire  = bus.up_valid_i & up_ready_q;
  assign dn_fire  = dn_valid & bus.dn_ready_i;

  // Flush wins over everything; a same-cycle dn_fire still counts as delivered.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (up_fire) begin
            main_d  = bus.up_data_i;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (up_fire && dn_fire) begin
            main_d = bus.up_data_i;
          end else if (up_fire) begin
            skid_d  = bus.up_data_i;
            state_d = FULL;
          end else if (dn_fire) begin
            main_d  = BUBBLE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (dn_fire) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // up_ready is precomputed from the next state so it leaves a flop directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= (state_d != FULL);
    end
  end

  assign bus.up_ready_o = up_ready_q;
  assign bus.dn_valid_o = dn_valid;
  assign bus.dn_data_o  = main_q;
  assign bus.occ_o      = state_q;

  ysyx_23060136_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (dn_valid & ~bus.dn_ready_i),
    .cnt (bus.stall_cnt_o)
  );

endmodule

// File: tb/tb_ysyx_23060136_pipe_skid_seg.sv
// Directed and random bench for the skid segment, compared every cycle against
// a queue-based model of the held beats.
module tb_ysyx_23060136_pipe_skid_seg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   cmp_en = 1'b0;

  logic [31:0] mq[$];
  int          mcnt = 0;

  always #5 clk = ~clk;

  ysyx_23060136_pipe_skid_seg_if #(.DATA_W(32), .CNT_W(4)) bus ();

  ysyx_23060136_pipe_skid_seg #(
    .DATA_W (32),
    .BUBBLE (32'h0),
    .CNT_W  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
    bus.up_valid_i = v;
    bus.up_data_i  = d;
    bus.dn_ready_i = r;
    bus.flush_i    = f;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Model: a FIFO of at most two beats plus a saturating stall count.
  initial begin : model_proc
    bit upf, dnf;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        mcnt = 0;
      end else begin
        upf = bus.up_valid_i && (mq.size() < 2);
        dnf = (mq.size() > 0) && bus.dn_ready_i;
        if ((mq.size() > 0) && !bus.dn_ready_i && (mcnt < 15)) mcnt++;
        if (dnf) void'(mq.pop_front());
        if (bus.flush_i) mq.delete();
        else if (upf) mq.push_back(bus.up_data_i);
      end
    end
  end

  initial begin : cmp_proc
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        ed = (mq.size() > 0) ? mq[0] : 32'h0;
        checkOutput("cmp_dn_valid", {31'b0, bus.dn_valid_o}, (mq.size() > 0) ? 32'd1 : 32'd0);
        checkOutput("cmp_up_ready", {31'b0, bus.up_ready_o}, (mq.size() < 2) ? 32'd1 : 32'd0);
        checkOutput("cmp_occ", {30'b0, bus.occ_o}, mq.size());
        checkOutput("cmp_dn_data", bus.dn_data_o, ed);
        checkOutput("cmp_stall_cnt", {28'b0, bus.stall_cnt_o}, mcnt);
      end
    end
  end

  initial begin
    logic [31:0] seq;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) step();
    checkOutput("rst0_dn_valid", {31'b0, bus.dn_valid_o}, 32'd0);
    checkOutput("rst0_up_ready", {31'b0, bus.up_ready_o}, 32'd1);
    checkOutput("rst0_occ", {30'b0, bus.occ_o}, 32'd0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Streaming
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0); step();
    checkOutput("stream_11", bus.dn_data_o, 32'h11);
    checkOutput("stream_occ", {30'b0, bus.occ_o}, 32'd1);
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0); step();
    checkOutput("stream_22", bus.dn_data_o, 32'h22);
    checkOutput("stream_rdy", {31'b0, bus.up_ready_o}, 32'd1);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0); step();
    checkOutput("stream_33", bus.dn_data_o, 32'h33);
    checkOutput("stream_occ3", {30'b0, bus.occ_o}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); step();
    checkOutput("stream_end_occ", {30'b0, bus.occ_o}, 32'd0);
    checkOutput("stream_cnt", {28'b0, bus.stall_cnt_o}, 32'd0);

    // Skid
    applyStimulus(1'b1, 32'hA, 1'b1, 1'b0); step();
    checkOutput("skid_busy_a", bus.dn_data_o, 32'hA);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0); step();
    checkOutput("skid_full_occ", {30'b0, bus.occ_o}, 32'd2);
    checkOutput("skid_full_rdy", {31'b0, bus.up_ready_o}, 32'd0);
    checkOutput("skid_full_a", bus.dn_data_o, 32'hA);
    checkOutput("model_occ_full", mq.size(), 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); step();
    checkOutput("skid_drain_b", bus.dn_data_o, 32'hB);
    checkOutput("skid_drain_occ", {30'b0, bus.occ_o}, 32'd1);
    step();
    checkOutput("skid_empty_valid", {31'b0, bus.dn_valid_o}, 32'd0);
    checkOutput("skid_cnt", {28'b0, bus.stall_cnt_o}, 32'd1);

    // Flush with simultaneous dn_fire
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b0); step();
    checkOutput("flush_pre_occ", {30'b0, bus.occ_o}, 32'd2);
    checkOutput("flush_pre_data", bus.dn_data_o, 32'h5);
    applyStimulus(1'b1, 32'h7, 1'b1, 1'b1); step();
    checkOutput("flush_occ", {30'b0, bus.occ_o}, 32'd0);
    checkOutput("flush_data", bus.dn_data_o, 32'h0);
    checkOutput("model_occ_flush", mq.size(), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("flush_no_late_beat", {31'b0, bus.dn_valid_o}, 32'd0);
    end
    checkOutput("flush_cnt", {28'b0, bus.stall_cnt_o}, 32'd2);

    // Counter saturation
    applyStimulus(1'b1, 32'h9, 1'b0, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) step();
    checkOutput("sat_cnt", {28'b0, bus.stall_cnt_o}, 32'd15);
    checkOutput("sat_data", bus.dn_data_o, 32'h9);
    checkOutput("model_cnt_sat", mcnt, 32'd15);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1); step();
    checkOutput("sat_after_flush", {28'b0, bus.stall_cnt_o}, 32'd15);
    checkOutput("sat_flush_occ", {30'b0, bus.occ_o}, 32'd0);

    // Asynchronous reset while FULL
    applyStimulus(1'b1, 32'h21, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0); step();
    checkOutput("rst_pre_occ", {30'b0, bus.occ_o}, 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_dn_valid", {31'b0, bus.dn_valid_o}, 32'd0);
    checkOutput("rst_up_ready", {31'b0, bus.up_ready_o}, 32'd1);
    checkOutput("rst_occ", {30'b0, bus.occ_o}, 32'd0);
    checkOutput("rst_data", bus.dn_data_o, 32'h0);
    checkOutput("rst_cnt", {28'b0, bus.stall_cnt_o}, 32'd0);
    step();
    rst = 1'b1;

    // Random traffic with occasional flush
    seq = 32'h100;
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), seq, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
      seq = seq + 32'd1;
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
